// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI flash read master streaming received bytes; SPI_FLASH_READER_ABORT_EN adds an abort input
module spi_flash_reader #(
    parameter int         CLK_DIV = 2,
    parameter logic [7:0] CMD     = 8'h03,
    parameter int         LEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
`ifdef SPI_FLASH_READER_ABORT_EN
    input  logic             abort,
`endif
    output logic             spi_cs,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = $clog2(3 * CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] CLK_LOW_LAST = HOLD_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(3 * CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_CS_HOLD} state_t;
    state_t state_q, state_d;

    logic [DIV_W-1:0]  div_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [4:0]        bit_cnt;
    logic [31:0]       shreg;
    logic [7:0]        rx_byte;
    logic              byte_pending;
    logic [LEN_W-1:0]  remaining;

    logic shifting, phase_end, clk_hold, rise, fall, abort_pend, abort_go, req_fire;

`ifdef SPI_FLASH_READER_ABORT_EN
    logic abort_q;

    // Abort is remembered until IDLE so a byte completing on the abort edge is not flagged last.
    always_ff @(posedge clk) begin
        if (reset) begin
            abort_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            abort_q <= 1'b0;
        end else if (abort && shifting) begin
            abort_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        shifting  = (state_q == S_CMD) || (state_q == S_DATA);
        phase_end = (div_cnt == DIV_LAST);
        // A new byte may only start clocking once the output slot is guaranteed free.
        clk_hold  = (state_q == S_DATA) && (bit_cnt == 5'd0) &&
                    (byte_pending || (out_valid && !out_ready));
        rise      = shifting && !spi_clk && phase_end && !clk_hold;
        fall      = shifting && spi_clk && phase_end;
`ifdef SPI_FLASH_READER_ABORT_EN
        abort_pend = abort_q || (abort && shifting);
`else
        abort_pend = 1'b0;
`endif
        abort_go  = abort_pend &&
                    (fall || ((state_q == S_DATA) && !spi_clk && (bit_cnt == 5'd0)));
        req_ready = (state_q == S_IDLE) && !out_valid;
        busy      = (state_q != S_IDLE);
        req_fire  = req_valid && req_ready && (req_len != '0);
        case (state_q)
            S_IDLE: begin
                if (req_fire) state_d = S_CMD;
            end
            S_CMD: begin
                if (abort_go) state_d = S_CS_HOLD;
                else if (fall && (bit_cnt == 5'd31)) state_d = S_DATA;
            end
            S_DATA: begin
                if (abort_go || (byte_pending && (remaining == LEN_W'(1)))) state_d = S_CS_HOLD;
            end
            S_CS_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            div_cnt      <= '0;
            hold_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_byte      <= '0;
            byte_pending <= 1'b0;
            remaining    <= '0;
            spi_cs       <= 1'b1;
            spi_clk      <= 1'b0;
            spi_mosi     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (byte_pending) begin
                byte_pending <= 1'b0;
                out_data     <= rx_byte;
                out_valid    <= 1'b1;
                out_last     <= (remaining == LEN_W'(1)) && !abort_pend;
                remaining    <= remaining - 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        spi_cs    <= 1'b0;
                        spi_clk   <= 1'b0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        spi_mosi  <= CMD[7];
                        shreg     <= {CMD[6:0], req_addr, 1'b0};
                        remaining <= req_len;
                    end
                end
                S_CMD, S_DATA: begin
                    if (rise) begin
                        spi_clk <= 1'b1;
                        div_cnt <= '0;
                    end else if (fall) begin
                        spi_clk <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (state_q == S_CMD) begin
                            spi_mosi <= (bit_cnt == 5'd31) ? 1'b0 : shreg[31];
                            shreg    <= {shreg[30:0], 1'b0};
                        end else begin
                            rx_byte <= {rx_byte[6:0], spi_miso};
                            if (bit_cnt == 5'd7) begin
                                bit_cnt      <= '0;
                                byte_pending <= 1'b1;
                            end
                        end
                    end else if (!phase_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (state_d == S_CS_HOLD) begin
                        spi_mosi <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                S_CS_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == CLK_LOW_LAST) spi_cs <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
